player_r_motion_ctl: RTL and testbench

- Frame-synchronous motion sequencer for the right-hand player sprite.
- Turns button inputs into the RP_x_pos offset consumed by the right-player renderer. The renderer's screen x is SCREEN_REF - RP_x_pos.
- Runs a walk/lunge/recover state machine, once per video frame.
- Clamps motion against the arena edges and the left player's body.
- Raises a one-cycle hit pulse when a lunge connects.

---
 rtl/player_motion_pkg.sv | 20 ++
 rtl/frame_tick_gen.sv | 16 +
 rtl/player_r_motion_ctl.sv | 133 +++++++++++++
 tb/tb_player_r_motion_ctl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/player_motion_pkg.sv
// player_motion_pkg: state encoding, shared arena constants and the clamped forward-move helper
// used by the player motion controllers.
package player_motion_pkg;

    localparam int SCREEN_REF = 885;
    localparam int WIDTH      = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WALK    = 3'd1,
        LUNGE   = 3'd2,
        RECOVER = 3'd3
    } state_e;

    // A position already past the limit holds still rather than snapping backward.
    function automatic logic [11:0] fwd_move(input logic [12:0] p, input logic [12:0] s, input logic [12:0] l);
        return 12'(p > l ? p : (p + s > l ? l : p + s));
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-cycle pulse on each rising edge of vsync.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vsync_i,
    output logic tick_o
);
    logic vsync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vsync_q <= 1'b0;
        else     vsync_q <= vsync_i;
    end

    assign tick_o = vsync_i & ~vsync_q;
endmodule

// File: rtl/player_r_motion_ctl.sv
// player_r_motion_ctl: frame-rate walk/lunge/recover sequencer for the right player sprite.
// Define PLAYER_R_MOTION_SYNC_EN to pass the buttons through 2-flop synchronisers.
module player_r_motion_ctl
    import player_motion_pkg::*;
#(
    parameter int SCREEN_REF     = player_motion_pkg::SCREEN_REF,
    parameter int WIDTH          = player_motion_pkg::WIDTH,
    parameter int X_START        = 0,
    parameter int X_MAX          = 820,
    parameter int STEP           = 2,
    parameter int LUNGE_STEP     = 6,
    parameter int LUNGE_FRAMES   = 8,
    parameter int RECOVER_FRAMES = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        left,
    input  logic        right,
    input  logic        lunge,
    input  logic [11:0] xpos_playerL,
    output logic [11:0] RP_x_pos,
    output logic [2:0]  state_out,
    output logic        lunge_active,
    output logic        hit
);
    localparam int CW = $clog2(LUNGE_FRAMES > RECOVER_FRAMES ? LUNGE_FRAMES : RECOVER_FRAMES);

    logic          tick;
    logic [2:0]    btn;
    state_e        state_q, state_d;
    logic [11:0]   pos_q, pos_d, walk_fwd, walk_back, lunge_fwd;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d, lact_q;
    logic [12:0]   pos, opp_edge, fwd_lim, lim;
    logic          lunge_hit;

    frame_tick_gen u_tick (
        .clk     (clk),
        .rst     (reset),
        .vsync_i (vsync_in),
        .tick_o  (tick)
    );

`ifdef PLAYER_R_MOTION_SYNC_EN
    logic [2:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {lunge, right, left};
            sync2_q <= sync1_q;
        end
    end

    assign btn = sync2_q;
`else
    assign btn = {lunge, right, left};
`endif

    assign pos       = {1'b0, pos_q};
    assign opp_edge  = {1'b0, xpos_playerL} + 13'(WIDTH);
    assign fwd_lim   = opp_edge >= 13'(SCREEN_REF) ? '0 : 13'(SCREEN_REF) - opp_edge;
    assign lim       = fwd_lim < 13'(X_MAX) ? fwd_lim : 13'(X_MAX);
    assign walk_fwd  = fwd_move(pos, 13'(STEP), lim);
    assign lunge_fwd = fwd_move(pos, 13'(LUNGE_STEP), lim);
    assign walk_back = pos_q >= 12'(STEP) ? pos_q - 12'(STEP) : '0;
    // Only the opponent limit counts as contact; stopping at X_MAX is silent.
    assign lunge_hit = pos + 13'(LUNGE_STEP) > fwd_lim;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE, WALK: begin
                    if (btn[2]) begin
                        pos_d   = lunge_fwd;
                        hit_d   = lunge_hit;
                        state_d = lunge_hit ? RECOVER : LUNGE;
                        cnt_d   = lunge_hit ? CW'(RECOVER_FRAMES - 1) : CW'(LUNGE_FRAMES - 1);
                    end else if (btn[0] ^ btn[1]) begin
                        state_d = WALK;
                        pos_d   = btn[0] ? walk_fwd : walk_back;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LUNGE: begin
                    if (lunge_hit || cnt_q == '0) begin
                        pos_d   = lunge_hit ? lunge_fwd : pos_q;
                        hit_d   = lunge_hit;
                        state_d = RECOVER;
                        cnt_d   = CW'(RECOVER_FRAMES - 1);
                    end else begin
                        pos_d = lunge_fwd;
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RECOVER: begin
                    state_d = cnt_q == '0 ? IDLE : RECOVER;
                    cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= 12'(X_START);
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            lact_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            lact_q  <= state_d == LUNGE;
        end
    end

    assign RP_x_pos     = pos_q;
    assign state_out    = state_q;
    assign lunge_active = lact_q;
    assign hit          = hit_q;
endmodule

// File: tb/tb_player_r_motion_ctl.sv
// tb_player_r_motion_ctl: randomized and directed checks of the right-player motion sequencer
// against a frame-level behavioural model.
module tb_player_r_motion_ctl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync_in = 1'b0;
    logic        left = 1'b0, right = 1'b0, lunge = 1'b0;
    logic [11:0] xpos_playerL = '0;
    logic [11:0] RP_x_pos;
    logic [2:0]  state_out;
    logic        lunge_active, hit;

    int n_checks = 0;
    int n_fail = 0;

    // Model: position, phase (0 idle, 1 walk, 2 lunge, 3 recover) and frames left in the phase.
    int m_pos, m_phase, m_left;
    bit m_hit;

    player_r_motion_ctl dut (
        .clk          (clk),
        .reset        (reset),
        .vsync_in     (vsync_in),
        .left         (left),
        .right        (right),
        .lunge        (lunge),
        .xpos_playerL (xpos_playerL),
        .RP_x_pos     (RP_x_pos),
        .state_out    (state_out),
        .lunge_active (lunge_active),
        .hit          (hit)
    );

    always #5 clk = ~clk;

    function automatic int min2(int a, int b);
        return a < b ? a : b;
    endfunction

    function automatic void model_reset();
        m_pos = 0; m_phase = 0; m_left = 0; m_hit = 0;
    endfunction

    // One lunge frame: advance 6 unless the opponent stops us.
    function automatic void lunge_frame(int opp_gap, int lim, bit first);
        if (m_pos + 6 > opp_gap) begin
            if (m_pos < lim) m_pos = lim;
            m_hit = 1; m_phase = 3; m_left = 12;
        end else if (!first && m_left == 1) begin
            m_phase = 3; m_left = 12;
        end else begin
            m_pos = min2(m_pos + 6, lim);
            m_phase = 2;
            m_left = first ? 8 : m_left - 1;
        end
    endfunction

    function automatic void model_tick(bit l, bit r, bit lg, int xl);
        int gap, lim;
        gap = 885 - (xl + 64);
        if (gap < 0) gap = 0;
        lim = min2(gap, 820);
        m_hit = 0;
        if (m_phase == 2) lunge_frame(gap, lim, 0);
        else if (m_phase == 3) begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = 0;
        end else if (lg) lunge_frame(gap, lim, 1);
        else if (l != r) begin
            m_phase = 1;
            if (l) m_pos = (m_pos > lim) ? m_pos : min2(m_pos + 2, lim);
            else   m_pos = (m_pos < 2) ? 0 : m_pos - 2;
        end else m_phase = 0;
    endfunction

    task automatic check_outputs(string tag);
        n_checks++;
        if (RP_x_pos !== 12'(m_pos)) begin
            n_fail++; $display("FAIL %s pos: got %0d expected %0d", tag, RP_x_pos, m_pos);
        end
        n_checks++;
        if (state_out !== 3'(m_phase)) begin
            n_fail++; $display("FAIL %s state: got %0d expected %0d", tag, state_out, m_phase);
        end
        n_checks++;
        if (lunge_active !== (m_phase == 2)) begin
            n_fail++; $display("FAIL %s lunge_active: got %0b expected %0b", tag, lunge_active, m_phase == 2);
        end
        n_checks++;
        if (hit !== m_hit) begin
            n_fail++; $display("FAIL %s hit: got %0b expected %0b", tag, hit, m_hit);
        end
    endtask

    task automatic do_frame(bit l, bit r, bit lg, string tag);
        left = l; right = r; lunge = lg;
        repeat (4) @(negedge clk);
        vsync_in = 1'b1;
        model_tick(l, r, lg, int'(xpos_playerL));
        @(posedge clk); #1;
        check_outputs(tag);
        @(negedge clk); vsync_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hit !== 1'b0) begin
            n_fail++; $display("FAIL %s hit_width: got %0b expected 0", tag, hit);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk); reset = 1'b1; left = 0; right = 0; lunge = 0; vsync_in = 0;
        model_reset();
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        reset = 1'b0;
    endtask

    task automatic test_walk();
        xpos_playerL = 12'd0;
        for (int i = 0; i < 5; i++) do_frame(1, 0, 0, "walk");
        n_checks++;
        if (RP_x_pos !== 12'd10 || state_out !== 3'd1) begin
            n_fail++; $display("FAIL walk_final: got pos %0d state %0d expected pos 10 state 1", RP_x_pos, state_out);
        end
    endtask

    task automatic test_both_pressed();
        for (int i = 0; i < 3; i++) do_frame(1, 1, 0, "both");
        n_checks++;
        if (RP_x_pos !== 12'd10 || state_out !== 3'd0) begin
            n_fail++; $display("FAIL both_final: got pos %0d state %0d expected pos 10 state 0", RP_x_pos, state_out);
        end
    endtask

    task automatic test_lunge_far();
        apply_reset();
        xpos_playerL = 12'd0;
        do_frame(0, 0, 1, "lunge_far");
        for (int i = 0; i < 7; i++) do_frame(1, 0, 1, "lunge_far");
        n_checks++;
        if (RP_x_pos !== 12'd48 || state_out !== 3'd2) begin
            n_fail++; $display("FAIL lunge_far_peak: got pos %0d state %0d expected pos 48 state 2", RP_x_pos, state_out);
        end
        for (int i = 0; i < 12; i++) do_frame(1, 0, 0, "recover");
        n_checks++;
        if (RP_x_pos !== 12'd48 || state_out !== 3'd3) begin
            n_fail++; $display("FAIL recover_hold: got pos %0d state %0d expected pos 48 state 3", RP_x_pos, state_out);
        end
        do_frame(1, 0, 0, "recover_exit");
        n_checks++;
        if (state_out !== 3'd0) begin
            n_fail++; $display("FAIL recover_exit_state: got %0d expected 0", state_out);
        end
    endtask

    task automatic test_lunge_clamp();
        apply_reset();
        xpos_playerL = 12'd0;
        for (int i = 0; i < 5; i++) do_frame(1, 0, 0, "clamp_walk");
        xpos_playerL = 12'd800;
        do_frame(0, 0, 1, "clamp1");
        do_frame(0, 0, 0, "clamp2");
        n_checks++;
        if (RP_x_pos !== 12'd21 || state_out !== 3'd3) begin
            n_fail++; $display("FAIL clamp_final: got pos %0d state %0d expected pos 21 state 3", RP_x_pos, state_out);
        end
        for (int i = 0; i < 12; i++) do_frame(0, 0, 0, "clamp_recover");
    endtask

    task automatic test_edges();
        apply_reset();
        xpos_playerL = 12'd820;
        do_frame(1, 0, 0, "edge_opp");
        xpos_playerL = 12'd0;
        do_frame(0, 1, 0, "edge_back");
        do_frame(0, 1, 0, "edge_back_sat");
        n_checks++;
        if (RP_x_pos !== 12'd0) begin
            n_fail++; $display("FAIL edge_zero: got %0d expected 0", RP_x_pos);
        end
        for (int i = 0; i < 413; i++) do_frame(1, 0, 0, "edge_xmax");
        n_checks++;
        if (RP_x_pos !== 12'd820) begin
            n_fail++; $display("FAIL edge_xmax_final: got %0d expected 820", RP_x_pos);
        end
        do_frame(0, 0, 1, "xmax_lunge");
    endtask

    task automatic test_reset_mid_lunge();
        apply_reset();
        xpos_playerL = 12'd0;
        for (int i = 0; i < 3; i++) do_frame(0, 0, 1, "mid_lunge");
        @(posedge clk); #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk); reset = 1'b0; lunge = 0;
    endtask

`ifdef PLAYER_R_MOTION_SYNC_EN
    task automatic test_sync();
        apply_reset();
        xpos_playerL = 12'd0;
        left = 1'b1;
        @(negedge clk); vsync_in = 1'b1;
        model_tick(0, 0, 0, 0);
        @(posedge clk); #1;
        check_outputs("sync_late");
        @(negedge clk); vsync_in = 1'b0; left = 1'b0;
        repeat (4) @(negedge clk);
        left = 1'b1;
        repeat (3) @(negedge clk);
        vsync_in = 1'b1;
        model_tick(1, 0, 0, 0);
        @(posedge clk); #1;
        check_outputs("sync_early");
        @(negedge clk); vsync_in = 1'b0; left = 1'b0;
    endtask
`endif

    task automatic test_random();
        bit l, r, lg;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                xpos_playerL = $urandom_range(0, 1) ? 12'($urandom_range(560, 840)) : 12'($urandom_range(0, 200));
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            lg = $urandom_range(0, 9) == 0;
            do_frame(l, r, lg, "random");
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_both_pressed();
        test_lunge_far();
        test_lunge_clamp();
        test_edges();
        test_reset_mid_lunge();
`ifdef PLAYER_R_MOTION_SYNC_EN
        test_sync();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
